// File: rtl/clock_set_controller.sv
// clock_set_controller: push-button sequencer for setting the clock counters.
// Produces per-counter mode selects, shared single-cycle up/down strobes with
// press auto-repeat, an inactivity timeout back to RUN and a blink enable.
module clock_set_controller #(
    parameter int unsigned HOLD_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned TIMEOUT       = 500_000_000,
    parameter int unsigned BLINK_HALF    = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode,
    input  logic btn_up,
    input  logic btn_down,
    output logic mode_second,
    output logic mode_minute,
    output logic mode_hour,
    output logic up,
    output logic down,
    output logic blink,
    output logic set_active
);

    typedef enum logic [1:0] {RUN, SET_SEC, SET_MIN, SET_HOUR} state_t;

    localparam int unsigned HOLD_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_DELAY - 1);
    localparam logic [HW-1:0] REP_LAST   = HW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t        r_state;
    logic          r_btn_mode, r_btn_up, r_btn_dn;
    logic          r_mode_d, r_up_d, r_dn_d;
    logic          r_hold_act, r_hold_up, r_hold_rep;
    logic [HW-1:0] r_hold_cnt;
    logic [TW-1:0] r_idle_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_mode_second, r_mode_minute, r_mode_hour;
    logic          r_up, r_dn, r_blink, r_set_active;

    logic          w_mode_rise, w_up_rise, w_dn_rise, w_in_set, w_both;
    state_t        w_next_state;
    logic          w_fire_up, w_fire_dn;
    logic          w_hold_act_n, w_hold_up_n, w_hold_rep_n;
    logic [HW-1:0] w_hold_cnt_n;
    logic          w_restart;

    assign w_mode_rise = r_btn_mode & ~r_mode_d;
    assign w_up_rise   = r_btn_up & ~r_up_d;
    assign w_dn_rise   = r_btn_dn & ~r_dn_d;
    assign w_in_set    = (r_state != RUN);
    assign w_both      = r_btn_up & r_btn_dn;

    // Next state, strobe decision and hold/auto-repeat tracking.
    // Priority: mode edge, then timeout, then strobes; anything else drops the hold.
    always_comb begin
        w_next_state = r_state;
        w_fire_up    = 1'b0;
        w_fire_dn    = 1'b0;
        w_hold_act_n = 1'b0;
        w_hold_up_n  = r_hold_up;
        w_hold_rep_n = 1'b0;
        w_hold_cnt_n = '0;
        if (w_mode_rise) begin
            unique case (r_state)
                RUN:      w_next_state = SET_SEC;
                SET_SEC:  w_next_state = SET_MIN;
                SET_MIN:  w_next_state = SET_HOUR;
                default:  w_next_state = RUN;
            endcase
        end else if (w_in_set && (r_idle_cnt == TO_LIMIT)) begin
            w_next_state = RUN;
        end else if (w_in_set && !w_both) begin
            if (w_up_rise) begin
                w_fire_up    = 1'b1;
                w_hold_act_n = 1'b1;
                w_hold_up_n  = 1'b1;
            end else if (w_dn_rise) begin
                w_fire_dn    = 1'b1;
                w_hold_act_n = 1'b1;
                w_hold_up_n  = 1'b0;
            end else if (r_hold_act && (r_hold_up ? r_btn_up : r_btn_dn)) begin
                w_hold_act_n = 1'b1;
                w_hold_rep_n = r_hold_rep;
                if (r_hold_cnt == (r_hold_rep ? REP_LAST : HOLD_LAST)) begin
                    w_fire_up    = r_hold_up;
                    w_fire_dn    = ~r_hold_up;
                    w_hold_rep_n = 1'b1;
                end else begin
                    w_hold_cnt_n = r_hold_cnt + 1'b1;
                end
            end
        end
    end

    // Blink phase and idle counter restart on entry to a SET state, on a strobe, and in RUN.
    assign w_restart = (w_next_state == RUN) || (w_next_state != r_state) || w_fire_up || w_fire_dn;

    // All state and registered outputs; reset preloads button pipelines to suppress edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_mode    <= btn_mode;
            r_btn_up      <= btn_up;
            r_btn_dn      <= btn_down;
            r_mode_d      <= btn_mode;
            r_up_d        <= btn_up;
            r_dn_d        <= btn_down;
            r_state       <= RUN;
            r_hold_act    <= 1'b0;
            r_hold_up     <= 1'b0;
            r_hold_rep    <= 1'b0;
            r_hold_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_blink_cnt   <= '0;
            r_mode_second <= 1'b1;
            r_mode_minute <= 1'b1;
            r_mode_hour   <= 1'b1;
            r_up          <= 1'b0;
            r_dn          <= 1'b0;
            r_blink       <= 1'b1;
            r_set_active  <= 1'b0;
        end else begin
            r_btn_mode    <= btn_mode;
            r_btn_up      <= btn_up;
            r_btn_dn      <= btn_down;
            r_mode_d      <= r_btn_mode;
            r_up_d        <= r_btn_up;
            r_dn_d        <= r_btn_dn;
            r_state       <= w_next_state;
            r_hold_act    <= w_hold_act_n;
            r_hold_up     <= w_hold_up_n;
            r_hold_rep    <= w_hold_rep_n;
            r_hold_cnt    <= w_hold_cnt_n;
            if (w_restart) begin
                r_idle_cnt  <= '0;
                r_blink_cnt <= '0;
                r_blink     <= 1'b1;
            end else begin
                if (r_idle_cnt != TO_LIMIT) begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
            r_mode_second <= (w_next_state != SET_SEC);
            r_mode_minute <= (w_next_state != SET_MIN);
            r_mode_hour   <= (w_next_state != SET_HOUR);
            r_up          <= w_fire_up;
            r_dn          <= w_fire_dn;
            r_set_active  <= (w_next_state != RUN);
        end
    end

    assign mode_second = r_mode_second;
    assign mode_minute = r_mode_minute;
    assign mode_hour   = r_mode_hour;
    assign up          = r_up;
    assign down        = r_dn;
    assign blink       = r_blink;
    assign set_active  = r_set_active;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed scenarios plus randomized button activity,
// checked every cycle against a timestamp-based reference model.
module tb_clock_set_controller;

    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int TOUT  = 40;
    localparam int BHALF = 5;

    logic clk, rst, btn_mode, btn_up, btn_down;
    logic mode_second, mode_minute, mode_hour, up, down, blink, set_active;

    clock_set_controller #(
        .HOLD_DELAY   (HOLD),
        .REPEAT_PERIOD(REP),
        .TIMEOUT      (TOUT),
        .BLINK_HALF   (BHALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .mode_second(mode_second),
        .mode_minute(mode_minute),
        .mode_hour  (mode_hour),
        .up         (up),
        .down       (down),
        .blink      (blink),
        .set_active (set_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_up  = 0;
    int n_dn  = 0;
    int n_set = 0;

    // reference model state: st 0=RUN 1=SEC 2=MIN 3=HOUR, times are edge numbers
    int n = 0;
    int st = 0;
    int t0 = 0;
    int last_act = 0;
    int bstart = 0;
    bit hold = 0, hdir = 0;
    bit p1m, p1u, p1d, p2m, p2u, p2d;
    bit e_up = 0, e_dn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit mr, ur, dr;
        int dt;
        n++;
        e_up = 0;
        e_dn = 0;
        if (rst) begin
            st  = 0;
            hold = 0;
            p1m = btn_mode; p2m = btn_mode;
            p1u = btn_up;   p2u = btn_up;
            p1d = btn_down; p2d = btn_down;
        end else begin
            mr = p1m && !p2m;
            ur = p1u && !p2u;
            dr = p1d && !p2d;
            if (mr) begin
                st = (st + 1) % 4;
                hold = 0;
                last_act = n;
                bstart = n;
            end else if (st != 0 && (n - 1 - last_act) >= TOUT) begin
                st = 0;
                hold = 0;
            end else if (st != 0 && !(p1u && p1d)) begin
                if (ur) begin
                    e_up = 1; hold = 1; hdir = 1; t0 = n;
                end else if (dr) begin
                    e_dn = 1; hold = 1; hdir = 0; t0 = n;
                end else if (hold && (hdir ? p1u : p1d)) begin
                    dt = n - t0;
                    if (dt == HOLD || (dt > HOLD && (dt - HOLD) % REP == 0)) begin
                        if (hdir) e_up = 1;
                        else      e_dn = 1;
                    end
                end else begin
                    hold = 0;
                end
            end else begin
                hold = 0;
            end
            if (e_up || e_dn) begin
                last_act = n;
                bstart = n;
            end
            p2m = p1m; p1m = btn_mode;
            p2u = p1u; p1u = btn_up;
            p2d = p1d; p1d = btn_down;
        end
    endtask

    task automatic tick();
        bit eb;
        @(posedge clk);
        model_step();
        #1;
        eb = (st == 0) ? 1'b1 : ((((n - bstart) / BHALF) % 2) == 0);
        check("mode_second", mode_second, st != 1);
        check("mode_minute", mode_minute, st != 2);
        check("mode_hour",   mode_hour,   st != 3);
        check("set_active",  set_active,  st != 0);
        check("up",          up,          e_up);
        check("down",        down,        e_dn);
        check("blink",       blink,       eb);
        if (up)         n_up++;
        if (down)       n_dn++;
        if (set_active) n_set++;
    endtask

    task automatic press_mode(input int gap);
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int k, last;
        logic pb;
        rst = 1'b1; btn_mode = 1'b1; btn_up = 1'b0; btn_down = 1'b0;

        // reset with mode held, then release: no transition
        repeat (3) tick();
        check("rst_mode_second", mode_second, 1);
        check("rst_blink", blink, 1);
        rst = 1'b0;
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (3) tick();
        check("held_mode_no_edge", set_active, 0);

        // first press: SET_SEC two edges after the press
        n_set = 0;
        btn_mode = 1'b1;
        tick();
        check("press_edge1", mode_second, 1);
        tick();
        check("press_edge2", mode_second, 0);
        btn_mode = 1'b0;
        repeat (8) tick();
        press_mode(10);
        press_mode(10);
        press_mode(10);
        check("set_active_cycles", n_set, 30);
        check("back_to_run", mode_hour, 1);

        // hold up in SET_MIN
        press_mode(5);
        press_mode(5);
        n_up = 0; n_dn = 0;
        btn_up = 1'b1;
        repeat (30) tick();
        btn_up = 1'b0;
        repeat (4) tick();
        check("hold_up_strobes", n_up, 7);
        check("hold_no_down", n_dn, 0);
        check("hold_min_sel", mode_minute, 0);
        pulse_reset();

        // both buttons together in SET_SEC
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        btn_up = 1'b1; btn_down = 1'b1;
        n_up = 0; n_dn = 0;
        repeat (20) tick();
        check("both_no_strobe", n_up + n_dn, 0);
        btn_down = 1'b0;
        repeat (10) tick();
        check("remaining_no_strobe", n_up + n_dn, 0);
        btn_up = 1'b0;
        tick();
        btn_down = 1'b1;
        repeat (3) tick();
        btn_down = 1'b0;
        repeat (3) tick();
        check("repress_down", n_dn, 1);
        check("repress_no_up", n_up, 0);
        pulse_reset();

        // timeout from SET_HOUR with blink spacing
        press_mode(4);
        press_mode(4);
        press_mode(4);
        check("in_set_hour", mode_hour, 0);
        k = 0; last = -1; pb = blink;
        while (set_active && k < 100) begin
            tick();
            k++;
            if (set_active && blink != pb) begin
                if (last >= 0) check("blink_gap", k - last, BHALF);
                last = k;
            end
            pb = blink;
        end
        check("timeout_run", set_active, 0);
        check("timeout_blink", blink, 1);
        pulse_reset();

        // simultaneous mode and up edges in SET_SEC
        press_mode(4);
        btn_mode = 1'b1; btn_up = 1'b1;
        n_up = 0;
        tick();
        btn_mode = 1'b0;
        repeat (5) tick();
        check("simul_no_up", n_up, 0);
        check("simul_min_sel", mode_minute, 0);
        btn_up = 1'b0;
        repeat (2) tick();
        pulse_reset();

        // up press in RUN gives nothing
        n_up = 0;
        btn_up = 1'b1;
        repeat (12) tick();
        btn_up = 1'b0;
        tick();
        check("run_no_up", n_up, 0);

        // randomized activity with occasional reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) btn_mode = ~btn_mode;
            if ($urandom_range(0, 99) < 6) btn_up   = ~btn_up;
            if ($urandom_range(0, 99) < 6) btn_down = ~btn_down;
            rst = ($urandom_range(0, 999) < 3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Sequences time-setting for the Millennium Clock counter chain. Turns three debounced push-button levels (mode, up, down) into the per-counter mode selects and the shared single-cycle up/down adjust strobes consumed by counter_seconds and its minute and hour siblings. Adds press auto-repeat, an inactivity timeout back to run mode, and a blink enable for the display driver.

## Interface
- HOLD_DELAY, 25_000_000: cycles from the first strobe of a held button to its first repeat strobe.
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeat strobes.
- TIMEOUT, 500_000_000: consecutive idle cycles in a SET state before the block forces RUN.
- BLINK_HALF, 12_500_000: blink half-period in cycles.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_mode  input  1  debounced mode button level.
- btn_up  input  1  debounced up button level.
- btn_down  input  1  debounced down button level.
- mode_second  output  1  1 = seconds counter runs; 0 = seconds counter is being set.
- mode_minute  output  1  same meaning for the minutes counter.
- mode_hour  output  1  same meaning for the hours counter.
- up  output  1  single-cycle increment strobe, shared by all counters.
- down  output  1  single-cycle decrement strobe, shared by all counters.
- blink  output  1  display enable for the digit being set; 1 = show.
- set_active  output  1  1 in any SET state.

## Operation
- States: RUN, SET_SEC, SET_MIN, SET_HOUR. All outputs are registered.
- A rising edge of btn_mode advances RUN→SET_SEC→SET_MIN→SET_HOUR→RUN.
- Rising-edge detection uses a one-cycle-delayed copy of each button.
- While rst is high, the delayed copies load the current button levels. A button held through reset therefore produces no edge.
- Mode outputs: all three are 1 in RUN. In SET_x, only the selected mode output is 0. At most one mode output is ever 0.
- Strobe rules:
  - Strobes are generated only in SET states. In RUN, up and down are held at 0.
  - A rising edge of btn_up with btn_down low produces one up strobe. The same rule applies to btn_down.
  - If both buttons are high, no strobe is produced and the hold counters clear.
  - When one of two simultaneously held buttons is released, the remaining button produces nothing until it is released and pressed again.
- Auto-repeat: while the pressed button stays high (and the other stays low), a strobe fires HOLD_DELAY cycles after the first strobe, then every REPEAT_PERIOD cycles. Releasing the button clears the hold counter.
- Simultaneous mode edge and up/down edge: the mode transition wins, no strobe is produced, and the hold state clears. The held button must be re-pressed.
- Timeout:
  - The idle counter clears on any mode edge, any strobe, and on entry to a SET state.
  - In a SET state, when the counter reaches TIMEOUT idle cycles, the state becomes RUN on the next edge.
  - The idle counter does not run in RUN.
- Blink:
  - blink is 1 in RUN.
  - On entry to a SET state, blink is 1; it then toggles every BLINK_HALF cycles.
  - Every strobe restarts the phase with blink = 1.

## Timing
- Reset values: state RUN; mode_second = mode_minute = mode_hour = 1; up = down = 0; blink = 1; set_active = 0; all internal counters 0.
- Edge latency: a button sampled high at edge k (low at edge k−1) drives its output change after edge k+1. This covers both a strobe and a mode transition.
- A strobe is exactly one cycle wide.
- up and down are never high together.
- Repeat spacing is exact in cycles: first strobe at cycle T, repeats at T+HOLD_DELAY and then T+HOLD_DELAY+n·REPEAT_PERIOD.
- rst asserted mid-operation takes effect at the next edge and overrides every other event, including mode edges, strobes and timeout.
- Counter widths are $clog2(param+1). Counters saturate rather than wrap.

## Test plan
All scenarios use HOLD_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=40, BLINK_HALF=5.
- Reset with btn_mode held high, then release → state RUN, all mode outputs 1, no transition. The next btn_mode press gives SET_SEC, with mode_second = 0 two edges after the press.
- Four btn_mode presses 10 cycles apart → mode outputs step through SET_SEC, SET_MIN, SET_HOUR, then all 1. set_active is 1 for exactly the three SET states.
- In SET_MIN, hold btn_up for 30 cycles → up strobes at T, T+8, T+12, T+16, T+20, T+24, T+28 (7 strobes); down stays 0; mode_minute stays 0.
- In SET_SEC:
  - Press btn_up and btn_down together for 20 cycles → zero strobes.
  - Release btn_down only → still zero strobes.
  - Re-press btn_down alone → exactly one down strobe.
- Enter SET_HOUR with no further presses → state returns to RUN after 40 idle cycles. blink toggles at 5-cycle intervals during SET_HOUR and is 1 after the return.
- btn_mode and btn_up rise on the same cycle in SET_SEC → transition to SET_MIN with no up strobe. In RUN, pressing btn_up produces no strobe.
